// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid FIFO between execute and memory stages, with
// overflow trap detection that squashes register and memory writes.
module ex_mem_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] aluout,
    input  logic         compout,
    input  logic         overflow,
    input  logic         unsig,
    input  logic [4:0]   rd,
    input  logic [2:0]   ctl,
    input  logic [W-1:0] storedata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_aluout,
    output logic         out_compout,
    output logic [4:0]   out_rd,
    output logic [2:0]   out_ctl,
    output logic [W-1:0] out_storedata,
    output logic         exc_ovf,
    output logic [7:0]   ovf_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [W-1:0] alu;
        logic         comp;
        logic [4:0]   rd;
        logic [2:0]   ctl;
        logic [W-1:0] sd;
    } entry_t;

    state_t     state_q, state_d;
    entry_t     head_q, head_d, skid_q, skid_d, in_e;
    logic       accept, pop, trap, trap_acc;
    logic       exc_q;
    logic [7:0] cnt_q;

    always_comb begin
        in_ready  = state_q != FULL;
        out_valid = state_q != EMPTY;
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
        trap      = overflow & ~unsig;
        trap_acc  = accept & trap & ~flush;
        // a trapping entry keeps memread but loses regwrite and memwrite
        in_e      = '{alu: aluout, comp: compout, rd: rd,
                      ctl: trap ? (ctl & 3'b010) : ctl, sd: storedata};
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    head_d  = in_e;
                end
                ONE: if (accept && pop) begin
                    head_d = in_e;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_e;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= trap_acc;
            cnt_q   <= (trap_acc && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    assign out_aluout    = head_q.alu;
    assign out_compout   = head_q.comp;
    assign out_rd        = head_q.rd;
    assign out_ctl       = out_valid ? head_q.ctl : 3'b000;
    assign out_storedata = head_q.sd;
    assign exc_ovf       = exc_q;
    assign ovf_count     = cnt_q;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed and random stimulus checked against a queue model
// of a two-deep FIFO with trap accounting.
module tb_ex_mem_skid;
    typedef struct {
        logic [31:0] a;
        logic        c;
        logic [4:0]  rd;
        logic [2:0]  ctl;
        logic [31:0] sd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, compout, overflow, unsig;
    logic        out_valid, out_ready, out_compout, exc_ovf;
    logic [31:0] aluout, storedata, out_aluout, out_storedata;
    logic [4:0]  rd, out_rd;
    logic [2:0]  ctl, out_ctl;
    logic [7:0]  ovf_count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   m_cnt = 0;
    bit   m_exc = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(.W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluout(aluout), .compout(compout), .overflow(overflow), .unsig(unsig),
        .rd(rd), .ctl(ctl), .storedata(storedata), .out_valid(out_valid),
        .out_ready(out_ready), .out_aluout(out_aluout), .out_compout(out_compout),
        .out_rd(out_rd), .out_ctl(out_ctl), .out_storedata(out_storedata),
        .exc_ovf(exc_ovf), .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() != 0);
        chk("exc_ovf", exc_ovf, m_exc);
        chk("ovf_count", ovf_count, m_cnt);
        if (q.size() != 0) begin
            chk("out_aluout", out_aluout, q[0].a);
            chk("out_compout", out_compout, q[0].c);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_ctl", out_ctl, q[0].ctl);
            chk("out_storedata", out_storedata, q[0].sd);
        end else begin
            chk("out_ctl_idle", out_ctl, 0);
        end
    endtask

    task automatic tick();
        bit acc, pp, trap;
        @(posedge clk);
        acc  = in_valid && q.size() < 2;
        pp   = out_ready && q.size() > 0;
        trap = overflow && !unsig;
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_exc = 0;
        end else if (flush) begin
            q.delete();
            m_exc = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back('{aluout, compout, rd, trap ? (ctl & 3'b010) : ctl, storedata});
            m_exc = acc && trap;
            if (m_exc && m_cnt < 255) m_cnt++;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input bit ov, input bit un,
                         input logic [2:0] c, input logic [4:0] r, input bit ordy);
        in_valid  = v;
        aluout    = a;
        overflow  = ov;
        unsig     = un;
        ctl       = c;
        rd        = r;
        out_ready = ordy;
        compout   = 1'($urandom);
        storedata = $urandom;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst_count", ovf_count, 0);
        // single pass
        drive(1, 32'hA, 0, 0, 3'b100, 5'd3, 1);
        tick();
        chk("pass_aluout", out_aluout, 32'hA);
        chk("pass_rd", out_rd, 3);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("pass_empty", out_valid, 0);
        // backpressure
        drive(1, 32'h1, 0, 0, 3'b100, 5'd1, 0);
        tick();
        drive(1, 32'h2, 0, 0, 3'b100, 5'd2, 0);
        tick();
        chk("bp_full", in_ready, 0);
        chk("bp_head1", out_aluout, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("bp_head2", out_aluout, 32'h2);
        tick();
        // trap and non-trap
        do_reset();
        drive(1, 32'h7, 1, 0, 3'b101, 5'd4, 1);
        tick();
        chk("trap_ctl", out_ctl, 3'b000);
        chk("trap_exc", exc_ovf, 1);
        chk("trap_cnt", ovf_count, 1);
        drive(1, 32'h8, 1, 1, 3'b101, 5'd4, 1);
        tick();
        chk("untrap_ctl", out_ctl, 3'b101);
        chk("untrap_exc", exc_ovf, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        // simultaneous accept and pop in ONE
        drive(1, 32'h5, 0, 0, 3'b100, 5'd5, 0);
        tick();
        drive(1, 32'h6, 0, 0, 3'b100, 5'd6, 1);
        tick();
        chk("ap_head", out_aluout, 32'h6);
        chk("ap_ready", in_ready, 1);
        // flush in FULL
        drive(1, 32'h9, 0, 0, 3'b100, 5'd7, 0);
        tick();
        chk("fl_full", in_ready, 0);
        flush = 1;
        drive(1, 32'hB, 1, 0, 3'b100, 5'd8, 1);
        tick();
        flush = 0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        // saturation
        for (int i = 0; i < 260; i++) begin
            drive(1, $urandom, 1, 0, 3'($urandom), 5'($urandom), 1);
            tick();
        end
        chk("sat_count", ovf_count, 255);
        drive(1, 32'hC, 0, 0, 3'b100, 5'd9, 0);
        do_reset();
        chk("sat_rst_count", ovf_count, 0);
        chk("sat_rst_valid", out_valid, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom), $urandom, ($urandom_range(3) == 0), 1'($urandom),
                  3'($urandom), 5'($urandom), ($urandom_range(2) != 0));
            flush = ($urandom_range(24) == 0);
            rst   = ($urandom_range(99) == 0);
            tick();
        end
        rst = 0; flush = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
